pattern_sequencer: RTL and testbench

Parametrised serial pattern generator. Replaces the fixed two-state generator with a loadable bit pattern of programmable length, a programmable bit period and a one-shot or repeat mode. Sits at the edge of a test or stimulus datapath and drives a single serial line with start/stop control and busy/done status.

---
 rtl/pattern_sequencer.sv | 107 ++++++++++
 tb/tb_pattern_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pattern_sequencer.sv
// Serial pattern generator: sends a captured bit pattern LSB first, each bit
// held for div+1 cycles, either once (with a done pulse) or looping forever.
module pattern_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] pattern,
  input  logic [IW-1:0]    len,
  input  logic [DIV_W-1:0] div,
  input  logic             repeat_en,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [IW-1:0]    bit_idx
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IW-1:0] LEN_MAX = IW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] pat_q;
  logic [IW-1:0]    len_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;
  logic             rep_q;
  logic [IW-1:0]    len_sat;
  logic [IW-1:0]    nxt_idx;

  // Only a non-power-of-2 WIDTH leaves len codes beyond the last pattern bit.
  generate
    if ((2 ** IW) != WIDTH) begin : g_sat
      assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
    end else begin : g_nosat
      assign len_sat = len;
    end
  endgenerate

  assign nxt_idx = bit_idx + IW'(1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      rep_q   <= 1'b0;
      cnt     <= '0;
      out     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          out     <= 1'b0;
          busy    <= 1'b0;
          bit_idx <= '0;
          if (start && !stop) begin
            pat_q <= pattern;
            len_q <= len_sat;
            div_q <= div;
            rep_q <= repeat_en;
            cnt   <= '0;
            out   <= pattern[0];
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            cnt     <= '0;
            out     <= 1'b0;
            busy    <= 1'b0;
            bit_idx <= '0;
          end else if (cnt == div_q) begin
            cnt <= '0;
            if (bit_idx < len_q) begin
              bit_idx <= nxt_idx;
              out     <= pat_q[nxt_idx];
            end else if (rep_q) begin
              // wrap straight to bit 0 so the repeat period has no bubble
              bit_idx <= '0;
              out     <= pat_q[0];
            end else begin
              state   <= IDLE;
              out     <= 1'b0;
              busy    <= 1'b0;
              bit_idx <= '0;
              done    <= 1'b1;
            end
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: one-shot, divided, repeat, abort,
// ignored start, back-to-back and asynchronous reset.
module tb_pattern_sequencer;
  localparam int WIDTH = 8;
  localparam int DIV_W = 8;
  localparam int IW    = $clog2(WIDTH);

  logic             clk = 1'b0;
  logic             rstn;
  logic             start, stop, repeat_en;
  logic [WIDTH-1:0] pattern;
  logic [IW-1:0]    len;
  logic [DIV_W-1:0] div;
  logic             out, busy, done;
  logic [IW-1:0]    bit_idx;

  int checks = 0;
  int errors = 0;

  pattern_sequencer #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pattern(pattern),
    .len(len), .div(div), .repeat_en(repeat_en), .out(out), .busy(busy),
    .done(done), .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out"},  32'(out),     32'd0);
    chk({tag, ".busy"}, 32'(busy),    32'd0);
    chk({tag, ".done"}, 32'(done),    32'd0);
    chk({tag, ".idx"},  32'(bit_idx), 32'd0);
  endtask

  // Start a sequence and check `cycles` active cycles against exp_out
  // (bit c = expected out in active cycle c).
  task automatic run_seq(input string tag, input logic [WIDTH-1:0] pat, input int l,
                         input int d, input logic rep, input int cycles,
                         input logic [63:0] exp_out);
    pattern = pat; len = IW'(l); div = DIV_W'(d); repeat_en = rep; start = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      tick();
      start = 1'b0;
      chk($sformatf("%s.out%0d", tag, c), 32'(out), 32'(exp_out[c]));
      chk($sformatf("%s.busy%0d", tag, c), 32'(busy), 32'd1);
      chk($sformatf("%s.done%0d", tag, c), 32'(done), 32'd0);
      chk($sformatf("%s.idx%0d", tag, c), 32'(bit_idx), 32'(((c / (d + 1)) % (l + 1))));
    end
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; stop = 1'b0; repeat_en = 1'b0;
    pattern = '0; len = '0; div = '0;
    repeat (3) tick();
    chk_idle("rst");
    rstn = 1'b1;
    tick();
    chk_idle("post_rst");

    // one-shot, div=0: out 0,1,0,0,1,1,0,1 then done
    run_seq("os8", 8'b1011_0010, 7, 0, 1'b0, 8, 64'b1011_0010);
    tick();
    chk("os8.done", 32'(done), 32'd1);
    chk("os8.busy_end", 32'(busy), 32'd0);
    chk("os8.out_end", 32'(out), 32'd0);
    tick();
    chk_idle("os8.after");

    // divided: out 1,1,1,0,0,0,1,1,1 then done
    run_seq("div", 8'b1010_0101, 2, 2, 1'b0, 9, 64'b1_1100_0111);
    tick();
    chk("div.done", 32'(done), 32'd1);
    chk("div.busy_end", 32'(busy), 32'd0);
    tick();
    chk_idle("div.after");

    // repeat: 0,1,1,0 x3 with no gap, done never asserts
    run_seq("rep", 8'b0000_0110, 3, 0, 1'b1, 12, 64'b0110_0110_0110);

    // stop mid-repeat
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("rep.stop");
    tick();
    chk_idle("rep.stop2");

    // ignored start while busy, then stop at cycle 5
    run_seq("ign_a", 8'b0000_0110, 3, 0, 1'b1, 2, 64'b10);
    pattern = 8'hFF; len = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign.out2", 32'(out), 32'd1);
    chk("ign.idx2", 32'(bit_idx), 32'd2);
    tick();
    chk("ign.out3", 32'(out), 32'd0);
    chk("ign.idx3", 32'(bit_idx), 32'd3);
    tick();
    chk("ign.out4", 32'(out), 32'd0);
    chk("ign.idx4", 32'(bit_idx), 32'd0);
    chk("ign.busy4", 32'(busy), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("abort");

    // start together with stop in IDLE is not accepted
    pattern = 8'hFF; len = 3'd7; start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk_idle("ss_idle");
    tick();
    chk_idle("ss_idle2");

    // back-to-back: 4 cycles, done cycle (idle, start raised), 4 cycles
    run_seq("b2b1", 8'b0000_0010, 1, 1, 1'b0, 4, 64'b1100);
    tick();
    chk("b2b.done", 32'(done), 32'd1);
    chk("b2b.gap_out", 32'(out), 32'd0);
    chk("b2b.gap_busy", 32'(busy), 32'd0);
    run_seq("b2b2", 8'b0000_0010, 1, 1, 1'b0, 4, 64'b1100);
    tick();
    chk("b2b2.done", 32'(done), 32'd1);
    tick();
    chk("b2b2.done_clr", 32'(done), 32'd0);

    // async reset mid repeat run
    run_seq("rr", 8'b0000_0110, 3, 0, 1'b1, 3, 64'b110);
    #2;
    rstn = 1'b0;
    #1;
    chk_idle("async_rst");
    tick();
    rstn = 1'b1;
    repeat (3) tick();
    chk_idle("rst_release");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule
